rvc_packer: RTL and testbench

RVC_PACKER -- requirements
Module: rvc_packer

---
 rtl/rvc_packer.sv | 228 ++++++++++++++++++++++
 tb/tb_rvc_packer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_packer.sv
// RV32I -> RVC halfword packer: compresses where possible and packs parcels into 32-bit words.
// Optional control-flow compression is enabled by defining RVC_BRANCH_COMPRESS_EN.
module rvc_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [15:0] comp_count
);

    typedef enum logic {S_EMPTY = 1'b0, S_HALF = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_residue;
    logic        r_out_valid;
    logic [31:0] r_out_word;
    logic [15:0] r_comp_count;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [11:0] w_immi;
    logic [11:0] w_imms;
    logic        w_rdp;
    logic        w_rs1p;
    logic        w_rs2p;
    logic        w_si_ok;
    logic        w_lw_ok;
    logic        w_sw_ok;
    logic        w_lui_ok;
    logic        w_alu_ok;
    logic [1:0]  w_sel;
    logic        w_is_c;
    logic [15:0] w_parcel;

    logic        w_in_fire;
    logic        w_flush_fire;
    logic        w_emit;
    logic [31:0] w_emit_word;
    logic        w_res_ld;
    logic [15:0] w_res_d;

    assign w_op   = in_inst[6:0];
    assign w_rd   = in_inst[11:7];
    assign w_f3   = in_inst[14:12];
    assign w_rs1  = in_inst[19:15];
    assign w_rs2  = in_inst[24:20];
    assign w_f7   = in_inst[31:25];
    assign w_immi = in_inst[31:20];
    assign w_imms = {in_inst[31:25], in_inst[11:7]};

    assign w_rdp   = (w_rd[4:3] == 2'b01);
    assign w_rs1p  = (w_rs1[4:3] == 2'b01);
    assign w_rs2p  = (w_rs2[4:3] == 2'b01);
    assign w_si_ok = (w_immi[11:5] == '0) || (w_immi[11:5] == '1);
    assign w_lw_ok = (w_immi[11:7] == '0) && (w_immi[1:0] == 2'b00);
    assign w_sw_ok = (w_imms[11:7] == '0) && (w_imms[1:0] == 2'b00);

    // lui immediate must be a sign-extended, nonzero 6-bit value
    assign w_lui_ok = (w_rd != 5'd0) && (w_rd != 5'd2)
                   && ((in_inst[31:17] == '0) || (in_inst[31:17] == '1))
                   && (in_inst[17:12] != '0);

    assign w_alu_ok = ((w_f7 == 7'b0100000) && (w_f3 == 3'b000))
                   || ((w_f7 == 7'b0000000) && (w_f3 == 3'b100))
                   || ((w_f7 == 7'b0000000) && (w_f3[2:1] == 2'b11));

    assign w_sel = (w_f3 == 3'b000) ? 2'b00 :
                   (w_f3 == 3'b100) ? 2'b01 :
                   w_f3[0]          ? 2'b11 : 2'b10;

`ifdef RVC_BRANCH_COMPRESS_EN
    logic [20:1] w_jimm;
    logic [12:1] w_bimm;
    assign w_jimm = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21]};
    assign w_bimm = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8]};
`endif

    always_comb begin
        w_is_c   = 1'b0;
        w_parcel = '0;
        if (w_op == 7'b0010011 && w_f3 == 3'b000) begin
            if (in_inst[31:7] == '0) begin
                w_is_c   = 1'b1;
                w_parcel = 16'h0001;
            end else if (w_rd == w_rs1 && w_rd != '0 && w_si_ok && w_immi != '0) begin
                w_is_c   = 1'b1;
                w_parcel = {3'b000, w_immi[5], w_rd, w_immi[4:0], 2'b01};
            end else if (w_rd != '0 && w_rs1 == '0 && w_si_ok) begin
                w_is_c   = 1'b1;
                w_parcel = {3'b010, w_immi[5], w_rd, w_immi[4:0], 2'b01};
            end
        end else if (w_op == 7'b0110111 && w_lui_ok) begin
            w_is_c   = 1'b1;
            w_parcel = {3'b011, in_inst[17], w_rd, in_inst[16:12], 2'b01};
        end else if (w_op == 7'b0000011 && w_f3 == 3'b010
                     && w_rdp && w_rs1p && w_lw_ok) begin
            w_is_c   = 1'b1;
            w_parcel = {3'b010, w_immi[5:3], w_rs1[2:0], w_immi[2], w_immi[6],
                        w_rd[2:0], 2'b00};
        end else if (w_op == 7'b0100011 && w_f3 == 3'b010
                     && w_rs2p && w_rs1p && w_sw_ok) begin
            w_is_c   = 1'b1;
            w_parcel = {3'b110, w_imms[5:3], w_rs1[2:0], w_imms[2], w_imms[6],
                        w_rs2[2:0], 2'b00};
        end else if (w_op == 7'b0010011 && w_f3 == 3'b101
                     && {w_f7[6], w_f7[4:0]} == '0 && w_rd == w_rs1
                     && w_rdp && w_rs2 != '0) begin
            w_is_c   = 1'b1;
            w_parcel = {3'b100, 2'b00, w_f7[5], w_rd[2:0], w_rs2, 2'b01};
        end else if (w_op == 7'b0010011 && w_f3 == 3'b111
                     && w_rd == w_rs1 && w_rdp && w_si_ok) begin
            w_is_c   = 1'b1;
            w_parcel = {3'b100, w_immi[5], 2'b10, w_rd[2:0], w_immi[4:0], 2'b01};
        end else if (w_op == 7'b0110011 && w_alu_ok
                     && w_rd == w_rs1 && w_rdp && w_rs2p) begin
            w_is_c   = 1'b1;
            w_parcel = {6'b100011, w_rd[2:0], w_sel, w_rs2[2:0], 2'b01};
        end else if (w_op == 7'b0110011 && w_f3 == 3'b000 && w_f7 == '0
                     && w_rd != '0 && w_rs2 != '0) begin
            if (w_rd == w_rs1) begin
                w_is_c   = 1'b1;
                w_parcel = {4'b1001, w_rd, w_rs2, 2'b10};
            end else if (w_rs1 == '0) begin
                w_is_c   = 1'b1;
                w_parcel = {4'b1000, w_rd, w_rs2, 2'b10};
            end
`ifdef RVC_BRANCH_COMPRESS_EN
        end else if (w_op == 7'b1101111 && w_rd[4:1] == '0
                     && ((w_jimm[20:11] == '0) || (w_jimm[20:11] == '1))) begin
            w_is_c   = 1'b1;
            w_parcel = {~w_rd[0], 2'b01, w_jimm[11], w_jimm[4], w_jimm[9:8],
                        w_jimm[10], w_jimm[6], w_jimm[7], w_jimm[3:1],
                        w_jimm[5], 2'b01};
        end else if (w_op == 7'b1100111 && w_f3 == 3'b000 && w_rd[4:1] == '0
                     && w_rs1 != '0 && w_immi == '0) begin
            w_is_c   = 1'b1;
            w_parcel = {3'b100, w_rd[0], w_rs1, 5'b00000, 2'b10};
        end else if (w_op == 7'b1100011 && w_f3[2:1] == 2'b00 && w_rs1p
                     && w_rs2 == '0
                     && ((w_bimm[12:8] == '0) || (w_bimm[12:8] == '1))) begin
            w_is_c   = 1'b1;
            w_parcel = {2'b11, w_f3[0], w_bimm[8], w_bimm[4:3], w_rs1[2:0],
                        w_bimm[7:6], w_bimm[2:1], w_bimm[5], 2'b01};
`endif
        end
    end

    assign in_ready     = !r_out_valid || out_ready;
    assign w_in_fire    = in_valid && in_ready;
    assign w_flush_fire = flush && !in_valid && in_ready && (r_state == S_HALF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_in_fire) begin
            if (w_is_c) w_state_nxt = (r_state == S_EMPTY) ? S_HALF : S_EMPTY;
        end else if (w_flush_fire) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_comb begin
        w_emit      = 1'b0;
        w_emit_word = '0;
        w_res_ld    = 1'b0;
        w_res_d     = r_residue;
        if (w_in_fire) begin
            if (r_state == S_EMPTY) begin
                if (w_is_c) begin
                    w_res_ld = 1'b1;
                    w_res_d  = w_parcel;
                end else begin
                    w_emit      = 1'b1;
                    w_emit_word = in_inst;
                end
            end else if (w_is_c) begin
                w_emit      = 1'b1;
                w_emit_word = {w_parcel, r_residue};
            end else begin
                w_emit      = 1'b1;
                w_emit_word = {in_inst[15:0], r_residue};
                w_res_ld    = 1'b1;
                w_res_d     = in_inst[31:16];
            end
        end else if (w_flush_fire) begin
            w_emit      = 1'b1;
            w_emit_word = {16'h0001, r_residue};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_residue    <= '0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_comp_count <= '0;
        end else begin
            if (w_res_ld) r_residue <= w_res_d;
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_word  <= w_emit_word;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_in_fire && w_is_c && r_comp_count != 16'hFFFF)
                r_comp_count <= r_comp_count + 16'd1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_word   = r_out_word;
    assign comp_count = r_comp_count;

endmodule

// File: tb/tb_rvc_packer.sv
// Bench for rvc_packer: directed scenarios plus random traffic
// checked against a halfword-queue reference model.
module tb_rvc_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [15:0] comp_count;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_ov = 1'b0;
    int          m_cnt = 0;
    logic [15:0] hq[$];
    logic [31:0] exq[$];
    bit          g_acc;

    rvc_packer dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .comp_count(comp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exv);
        n_tests++;
        assert (obs === exv) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exv);
        end
    endtask

    function automatic bit pr(input int r);
        return (r >= 8) && (r <= 15);
    endfunction

    // Reference compressor: decodes fields to integers, applies the rules
    function automatic bit mc(input logic [31:0] x, output logic [15:0] p);
        int op, rd, f3, rs1, rs2, f7, ii, si, off, v, sel;
        op  = int'(x[6:0]);
        rd  = int'(x[11:7]);
        f3  = int'(x[14:12]);
        rs1 = int'(x[19:15]);
        rs2 = int'(x[24:20]);
        f7  = int'(x[31:25]);
        ii  = int'($signed(x[31:20]));
        si  = int'($signed({x[31:25], x[11:7]}));
        p   = 16'h0;
        if (op == 19 && f3 == 0) begin
            if (rd == 0 && rs1 == 0 && ii == 0) begin
                p = 16'h0001; return 1'b1;
            end
            if (ii >= -32 && ii <= 31) begin
                if (rd == rs1 && rd != 0 && ii != 0) begin
                    p = 16'(32'h0001 | ((ii & 32) << 7) | (rd << 7)
                            | ((ii & 31) << 2));
                    return 1'b1;
                end
                if (rd != 0 && rs1 == 0) begin
                    p = 16'(32'h4001 | ((ii & 32) << 7) | (rd << 7)
                            | ((ii & 31) << 2));
                    return 1'b1;
                end
            end
            return 1'b0;
        end
        if (op == 55 && rd != 0 && rd != 2) begin
            v = int'($signed(x[31:12]));
            if (v != 0 && v >= -32 && v <= 31) begin
                p = 16'(32'h6001 | ((v & 32) << 7) | (rd << 7) | ((v & 31) << 2));
                return 1'b1;
            end
            return 1'b0;
        end
        if (op == 3 && f3 == 2 && pr(rd) && pr(rs1)
            && ii >= 0 && ii <= 124 && ii % 4 == 0) begin
            p = 16'(32'h4000 | (((ii >> 3) & 7) << 10) | ((rs1 - 8) << 7)
                    | (((ii >> 2) & 1) << 6) | (((ii >> 6) & 1) << 5)
                    | ((rd - 8) << 2));
            return 1'b1;
        end
        if (op == 35 && f3 == 2 && pr(rs2) && pr(rs1)
            && si >= 0 && si <= 124 && si % 4 == 0) begin
            p = 16'(32'hC000 | (((si >> 3) & 7) << 10) | ((rs1 - 8) << 7)
                    | (((si >> 2) & 1) << 6) | (((si >> 6) & 1) << 5)
                    | ((rs2 - 8) << 2));
            return 1'b1;
        end
        if (op == 19 && f3 == 5 && (f7 == 0 || f7 == 32)
            && rd == rs1 && pr(rd) && rs2 != 0) begin
            p = 16'(32'h8001 | ((f7 == 32 ? 1 : 0) << 10) | ((rd - 8) << 7)
                    | (rs2 << 2));
            return 1'b1;
        end
        if (op == 19 && f3 == 7 && rd == rs1 && pr(rd)
            && ii >= -32 && ii <= 31) begin
            p = 16'(32'h8801 | ((ii & 32) << 7) | ((rd - 8) << 7)
                    | ((ii & 31) << 2));
            return 1'b1;
        end
        if (op == 51) begin
            sel = -1;
            if (f3 == 0 && f7 == 32) sel = 0;
            if (f3 == 4 && f7 == 0)  sel = 1;
            if (f3 == 6 && f7 == 0)  sel = 2;
            if (f3 == 7 && f7 == 0)  sel = 3;
            if (sel >= 0 && rd == rs1 && pr(rd) && pr(rs2)) begin
                p = 16'(32'h8C01 | ((rd - 8) << 7) | (sel << 5) | ((rs2 - 8) << 2));
                return 1'b1;
            end
            if (f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0) begin
                if (rd == rs1) begin
                    p = 16'(32'h9002 | (rd << 7) | (rs2 << 2)); return 1'b1;
                end
                if (rs1 == 0) begin
                    p = 16'(32'h8002 | (rd << 7) | (rs2 << 2)); return 1'b1;
                end
            end
            return 1'b0;
        end
`ifdef RVC_BRANCH_COMPRESS_EN
        if (op == 111 && rd <= 1) begin
            off = int'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            if (off >= -2048 && off <= 2046) begin
                p = 16'((rd == 1 ? 32'h2001 : 32'hA001)
                        | (((off >> 11) & 1) << 12) | (((off >> 4) & 1) << 11)
                        | (((off >> 8) & 3) << 9) | (((off >> 10) & 1) << 8)
                        | (((off >> 6) & 1) << 7) | (((off >> 7) & 1) << 6)
                        | (((off >> 1) & 7) << 3) | (((off >> 5) & 1) << 2));
                return 1'b1;
            end
        end
        if (op == 103 && f3 == 0 && rd <= 1 && rs1 != 0 && ii == 0) begin
            p = 16'(32'h8002 | (rd << 12) | (rs1 << 7));
            return 1'b1;
        end
        if (op == 99 && f3 <= 1 && pr(rs1) && rs2 == 0) begin
            off = int'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            if (off >= -256 && off <= 254) begin
                p = 16'(32'hC001 | (f3 << 13) | (((off >> 8) & 1) << 12)
                        | (((off >> 3) & 3) << 10) | ((rs1 - 8) << 7)
                        | (((off >> 6) & 3) << 5) | (((off >> 1) & 3) << 3)
                        | (((off >> 5) & 1) << 2));
                return 1'b1;
            end
        end
`endif
        return 1'b0;
    endfunction

    // One clock: predict the handshake, advance, then update model and compare
    task automatic tick();
        bit rdy, acc, flf, xfer, em, c;
        logic [31:0] w0;
        logic [15:0] pc, h0, h1;
        #1;
        rdy  = !m_ov || out_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        acc  = in_valid && rdy;
        flf  = flush && !in_valid && rdy && (hq.size() == 1);
        xfer = m_ov && out_ready;
        w0   = out_word;
        @(posedge clk);
        #1;
        g_acc = acc;
        if (xfer && exq.size() > 0) chk("xfer_word", w0, exq.pop_front());
        em = 1'b0;
        if (acc) begin
            c = mc(in_inst, pc);
            if (c) begin
                hq.push_back(pc);
                if (m_cnt < 65535) m_cnt++;
            end else begin
                hq.push_back(in_inst[15:0]);
                hq.push_back(in_inst[31:16]);
            end
        end
        if (flf) hq.push_back(16'h0001);
        if (hq.size() >= 2) begin
            h0 = hq.pop_front();
            h1 = hq.pop_front();
            exq.push_back({h1, h0});
            em = 1'b1;
        end
        m_ov = em || (m_ov && !xfer);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("comp_count", {16'b0, comp_count}, 32'(m_cnt));
        if (m_ov && exq.size() > 0) chk("out_word", out_word, exq[0]);
    endtask

    task automatic send(input logic [31:0] x);
        in_valid = 1'b1;
        in_inst  = x;
        g_acc    = 1'b0;
        for (int i = 0; i < 50 && !g_acc; i++) tick();
        chk("send_accept", {31'b0, g_acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_count", {16'b0, comp_count}, 32'd0);
        chk("rst_word", out_word, 32'd0);
        hq.delete();
        exq.delete();
        m_ov  = 1'b0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itp(input int imm, input int rs1,
                                        input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] rtp(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd, input int op);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] gen();
        int k, rd, rs1, rs2, im, off, f3;
        k   = int'($urandom_range(0, 12));
        rd  = int'($urandom_range(0, 17));
        rs1 = int'($urandom_range(0, 17));
        rs2 = int'($urandom_range(0, 17));
        im  = int'($urandom_range(0, 90)) - 45;
        off = $urandom_range(0, 1) ? 4 * int'($urandom_range(0, 33))
                                   : int'($urandom_range(0, 200));
        if ($urandom_range(0, 1) == 1) rs1 = rd;
        case (k)
            0: return itp(im, $urandom_range(0, 2) == 0 ? 0 : rs1, 0, rd, 19);
            1: begin
                if ($urandom_range(0, 1) == 1) off = im;
                else off = int'($urandom_range(0, 1048575));
                return {off[19:0], rd[4:0], 7'h37};
            end
            2: return itp(off, rs1, 2, rd, 3);
            3: return {off[11:5], rs2[4:0], rs1[4:0], 3'b010, off[4:0], 7'h23};
            4: return rtp(32 * int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 31)), rs1, 5, rd, 19);
            5: return itp(im, rs1, 7, rd, 19);
            6: begin
                f3 = $urandom_range(0, 1) ? 0 : int'($urandom_range(6, 7));
                if ($urandom_range(0, 3) == 0) f3 = 4;
                return rtp(f3 == 0 ? 32 : 0, rs2, rs1, f3, rd, 51);
            end
            7: return rtp(0, rs2, $urandom_range(0, 1) ? 0 : rs1, 0, rd, 51);
            8: return rtp(0, int'($urandom_range(0, 31)), rs1, 1, rd, 19);
            9: begin
                off = 2 * (int'($urandom_range(0, 2200)) - 1100);
                rd  = int'($urandom_range(0, 2));
                return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6F};
            end
            10: return itp(4 * int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 3)), 0,
                           int'($urandom_range(0, 2)), 103);
            11: begin
                off = 2 * (int'($urandom_range(0, 300)) - 150);
                rs2 = int'($urandom_range(0, 1));
                f3  = int'($urandom_range(0, 1));
                return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                        off[4:1], off[11], 7'h63};
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        do_reset();

        // two c.addi parcels pack into one word
        send(32'h00140413);
        chk("req28_pending", {31'b0, out_valid}, 32'd0);
        send(32'h00140413);
        chk("req28_word", out_word, 32'h04050405);
        chk("req28_count", {16'b0, comp_count}, 32'd2);
        tick();

        // parcel + 32-bit straddle, then flush pads with c.nop
        do_reset();
        send(32'h00140413);
        send(32'h007302B3);
        chk("req29_word0", out_word, 32'h02B30405);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("req29_word1", out_word, 32'h00010073);
        chk("req29_count", {16'b0, comp_count}, 32'd1);
        tick();

        do_reset();
        send(32'h00000013);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("req30_word", out_word, 32'h00010001);
        tick();

        do_reset();
        send(32'h0080006F);
`ifdef RVC_BRANCH_COMPRESS_EN
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("req31_word", out_word, 32'h0001A021);
`else
        chk("req31_word", out_word, 32'h0080006F);
`endif
        tick();

        // slli stays 32-bit
        do_reset();
        send(32'h00141413);
        chk("slli_word", out_word, 32'h00141413);
        chk("slli_count", {16'b0, comp_count}, 32'd0);
        tick();

        // backpressure: word held, no acceptance while stalled
        do_reset();
        out_ready = 1'b0;
        send(32'h007302B3);
        in_valid = 1'b1;
        in_inst  = 32'h00140413;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_word", out_word, 32'h007302B3);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("unstall_count", {16'b0, comp_count}, 32'd1);
        tick();

        // reset while a residue is pending discards it
        do_reset();
        send(32'h00140413);
        do_reset();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b0;
        chk("req33_no_emit", {31'b0, out_valid}, 32'd0);

        // random traffic with random backpressure and flushes
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = gen();
            flush     = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b0;
        chk("drain_idle", {31'b0, out_valid}, 32'd0);

        // comp_count saturation
        do_reset();
        in_valid = 1'b1;
        in_inst  = 32'h00000013;
        for (int i = 0; i < 65540; i++) tick();
        in_valid = 1'b0;
        chk("sat_count", {16'b0, comp_count}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
